forward_hazard_unit: RTL and testbench

// Producer of the FWDA/FWDB selects consumed by the EX-stage operand forwarding muxes.

---
 rtl/forward_hazard_unit.sv | 149 ++++++++++++++
 tb/tb_forward_hazard_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding selects plus load-use stall and branch-flush control
// for the 5-stage RV32I core, tracked by a private shadow of the EX/MEM/WB stages.
module forward_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             VALID_ID,
  input  logic [REG_W-1:0] RS1_ID,
  input  logic [REG_W-1:0] RS2_ID,
  input  logic             USES_RS1_ID,
  input  logic             USES_RS2_ID,
  input  logic [REG_W-1:0] RD_ID,
  input  logic             REGWRITE_ID,
  input  logic             MEMREAD_ID,
  input  logic             FLUSH_EX,
  input  logic             HOLD,
  output logic [1:0]       FWDA,
  output logic [1:0]       FWDB,
  output logic             STALL_IF_ID,
  output logic             BUBBLE_EX,
  output logic             FLUSH_IF_ID,
  output logic [CNT_W-1:0] STALL_COUNT
);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             ex_valid_r;
  logic [REG_W-1:0] ex_rs1_r;
  logic [REG_W-1:0] ex_rs2_r;
  logic             ex_use1_r;
  logic             ex_use2_r;
  logic [REG_W-1:0] ex_rd_r;
  logic             ex_regwrite_r;
  logic             ex_memread_r;
  logic [REG_W-1:0] mem_rd_r;
  logic             mem_regwrite_r;
  logic             mem_memread_r;
  logic [REG_W-1:0] wb_rd_r;
  logic             wb_regwrite_r;
  logic [CNT_W-1:0] stall_count_r;

  logic             load_use_s;
  logic             bubble_ex_s;
  logic             ex_kill_s;
  logic [1:0]       fwda_s;
  logic [1:0]       fwdb_s;

  // ALUOUT_MEM of a load is its address, so a load sitting in MEM is never a source.
  function automatic logic [1:0] fwd_sel(
    input logic             use_rs,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] m_rd,
    input logic             m_rw,
    input logic             m_mr,
    input logic [REG_W-1:0] w_rd,
    input logic             w_rw
  );
    logic [1:0] sel;
    if (use_rs && m_rw && !m_mr && (m_rd != REG_ZERO) && (m_rd == rs)) begin
      sel = 2'b01;
    end else if (use_rs && w_rw && (w_rd != REG_ZERO) && (w_rd == rs)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding select decode
  always_comb begin
    load_use_s = 1'b0;
    if (VALID_ID && ex_valid_r && ex_memread_r && (ex_rd_r != REG_ZERO) && !FLUSH_EX) begin
      load_use_s = (USES_RS1_ID && (RS1_ID == ex_rd_r)) ||
                   (USES_RS2_ID && (RS2_ID == ex_rd_r));
    end else begin
      load_use_s = 1'b0;
    end
    bubble_ex_s = load_use_s | FLUSH_EX;
    ex_kill_s   = bubble_ex_s | !VALID_ID;
    fwda_s = fwd_sel(ex_use1_r, ex_rs1_r, mem_rd_r, mem_regwrite_r, mem_memread_r,
                     wb_rd_r, wb_regwrite_r);
    fwdb_s = fwd_sel(ex_use2_r, ex_rs2_r, mem_rd_r, mem_regwrite_r, mem_memread_r,
                     wb_rd_r, wb_regwrite_r);
  end

  assign FWDA        = fwda_s;
  assign FWDB        = fwdb_s;
  assign STALL_IF_ID = load_use_s | HOLD;
  assign BUBBLE_EX   = bubble_ex_s;
  assign FLUSH_IF_ID = FLUSH_EX;
  assign STALL_COUNT = stall_count_r;

  // Shadow pipeline advance; HOLD freezes every stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r     <= 1'b0;
      ex_rs1_r       <= REG_ZERO;
      ex_rs2_r       <= REG_ZERO;
      ex_use1_r      <= 1'b0;
      ex_use2_r      <= 1'b0;
      ex_rd_r        <= REG_ZERO;
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      mem_rd_r       <= REG_ZERO;
      mem_regwrite_r <= 1'b0;
      mem_memread_r  <= 1'b0;
      wb_rd_r        <= REG_ZERO;
      wb_regwrite_r  <= 1'b0;
    end else if (!HOLD) begin
      if (ex_kill_s) begin
        ex_valid_r    <= 1'b0;
        ex_rs1_r      <= REG_ZERO;
        ex_rs2_r      <= REG_ZERO;
        ex_use1_r     <= 1'b0;
        ex_use2_r     <= 1'b0;
        ex_rd_r       <= REG_ZERO;
        ex_regwrite_r <= 1'b0;
        ex_memread_r  <= 1'b0;
      end else begin
        ex_valid_r    <= 1'b1;
        ex_rs1_r      <= RS1_ID;
        ex_rs2_r      <= RS2_ID;
        ex_use1_r     <= USES_RS1_ID;
        ex_use2_r     <= USES_RS2_ID;
        ex_rd_r       <= RD_ID;
        ex_regwrite_r <= REGWRITE_ID;
        ex_memread_r  <= MEMREAD_ID;
      end
      mem_rd_r       <= ex_rd_r;
      mem_regwrite_r <= ex_regwrite_r;
      mem_memread_r  <= ex_memread_r;
      wb_rd_r        <= mem_rd_r;
      wb_regwrite_r  <= mem_regwrite_r;
    end
  end

  // Saturating count of load-use stall cycles that actually cost a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (load_use_s && !HOLD && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed table-driven bench for forward_hazard_unit with hand-written reset sequences.
module tb_forward_hazard_unit;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       ho;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       bu;
    logic       flo;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 35;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_id, uses_rs1_id, uses_rs2_id, regwrite_id, memread_id, flush_ex, hold;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic [1:0]  fwda, fwdb;
  logic        stall_if_id, bubble_ex, flush_if_id;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;
  vec_t vecs [NV];

  forward_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .VALID_ID(valid_id), .RS1_ID(rs1_id), .RS2_ID(rs2_id),
    .USES_RS1_ID(uses_rs1_id), .USES_RS2_ID(uses_rs2_id),
    .RD_ID(rd_id), .REGWRITE_ID(regwrite_id), .MEMREAD_ID(memread_id),
    .FLUSH_EX(flush_ex), .HOLD(hold),
    .FWDA(fwda), .FWDB(fwdb), .STALL_IF_ID(stall_if_id), .BUBBLE_EX(bubble_ex),
    .FLUSH_IF_ID(flush_if_id), .STALL_COUNT(stall_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int v, input int rs1, input int rs2, input int u1,
                              input int u2, input int rd, input int rw, input int mr,
                              input int fl, input int ho, input int fa, input int fb,
                              input int st, input int bu, input int flo, input int cnt);
    vec_t r;
    r.valid = 1'(v);  r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'(u1); r.u2 = 1'(u2);
    r.rd = 5'(rd);    r.rw = 1'(rw);   r.mr = 1'(mr);   r.fl = 1'(fl); r.ho = 1'(ho);
    r.fa = 2'(fa);    r.fb = 2'(fb);   r.st = 1'(st);   r.bu = 1'(bu); r.flo = 1'(flo);
    r.cnt = 16'(cnt);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    valid_id = t.valid; rs1_id = t.rs1; rs2_id = t.rs2;
    uses_rs1_id = t.u1; uses_rs2_id = t.u2; rd_id = t.rd;
    regwrite_id = t.rw; memread_id = t.mr; flush_ex = t.fl; hold = t.ho;
  endtask

  task automatic check_outs(input string tag, input vec_t t);
    check({tag, " fwda"},   int'(fwda),        int'(t.fa));
    check({tag, " fwdb"},   int'(fwdb),        int'(t.fb));
    check({tag, " stall"},  int'(stall_if_id), int'(t.st));
    check({tag, " bubble"}, int'(bubble_ex),   int'(t.bu));
    check({tag, " flush"},  int'(flush_if_id), int'(t.flo));
    check({tag, " count"},  int'(stall_count), int'(t.cnt));
  endtask

  // Entered at posedge+1; samples at posedge+4, returns at the next posedge+1.
  task automatic step(input string tag, input vec_t t, input bit do_check);
    drive(t);
    #3;
    if (do_check) check_outs(tag, t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t nop;
    nop = mk(0,0,0,0,0,0,0,0, 0,0, 0,0,0,0,0,0);
    //            v rs1 rs2 u1 u2 rd rw mr fl ho | fa fb st bu fl cnt
    vecs[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // ADD x5
    vecs[1]  = mk(1, 5, 3, 1, 1, 7, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // SUB x7,x5,x3
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0); // SUB in EX
    vecs[3]  = mk(1, 0, 0, 1, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // ADDI x5
    vecs[4]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // ADD x5
    vecs[5]  = mk(1, 5, 5, 1, 1, 9, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // x9 = x5 op x5
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0); // MEM beats WB
    vecs[7]  = mk(1, 9, 4, 1, 1,10, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0); // WB forward
    vecs[9]  = mk(1, 2, 0, 1, 0, 6, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0); // LW x6
    vecs[10] = mk(1, 1, 6, 1, 1,11, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0); // load-use
    vecs[11] = mk(1, 1, 6, 1, 1,11, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1); // replay
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 1); // load in WB
    vecs[13] = mk(1, 2, 0, 1, 0, 6, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1); // LW x6
    vecs[14] = mk(1, 6, 0, 1, 0,12, 1, 0, 1, 0,   0, 0, 0, 1, 1, 1); // flush wins
    vecs[15] = mk(1, 6, 0, 1, 0,13, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1); // LW still advanced
    vecs[17] = mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1); // ADDI x0
    vecs[18] = mk(1, 0, 0, 1, 1,14, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    vecs[19] = mk(1, 3, 0, 1, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1); // x0 not forwarded; LW x0
    vecs[20] = mk(1, 0, 0, 1, 0,15, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1); // LW x0 no stall
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    vecs[22] = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1); // ADD x5
    vecs[23] = mk(1, 5, 5, 1, 1,16, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    vecs[24] = mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 1,   1, 1, 1, 0, 0, 1); // HOLD x3
    vecs[25] = mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 1,   1, 1, 1, 0, 0, 1);
    vecs[26] = mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 1,   1, 1, 1, 0, 0, 1);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1); // state intact
    vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    vecs[30] = mk(1, 2, 0, 1, 0, 6, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1); // LW x6
    vecs[31] = mk(1, 6, 0, 1, 0,17, 1, 0, 0, 1,   0, 0, 1, 1, 0, 1); // load-use under HOLD
    vecs[32] = mk(1, 6, 0, 1, 0,17, 1, 0, 0, 0,   0, 0, 1, 1, 0, 1);
    vecs[33] = mk(1, 6, 0, 1, 0,17, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2);
    vecs[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 2);

    // Reset state, including HOLD forcing the stall while in reset
    rst_n = 1'b0;
    drive(nop);
    hold = 1'b1;
    #2;
    check("reset hold stall", int'(stall_if_id), 1);
    hold = 1'b0;
    #1;
    check_outs("reset", nop);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Async reset asserted in the middle of a load-use stall
    step("pre-lw", mk(1,2,0,1,0,6,1,1,0,0, 0,0,0,0,0,2), 1'b1);
    drive(mk(1,1,6,1,1,11,1,0,0,0, 0,0,0,0,0,0));
    #2;
    check("mid stall before reset", int'(stall_if_id), 1);
    rst_n = 1'b0;
    #1;
    check_outs("in reset", nop);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post0", mk(1,1,2,1,1,5,1,0,0,0, 0,0,0,0,0,0), 1'b1);
    step("post1", mk(1,5,3,1,1,7,1,0,0,0, 0,0,0,0,0,0), 1'b1);
    step("post2", mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
